// File: rtl/cmd_sequencer.sv
// Command sequencer: round-robin arbitration between two requesters, then
// byte-serial frame output paced by ticker rising edges (load/gap phases).
module cmd_sequencer #(
    parameter int LOAD_TICKS = 80,
    parameter int GAP_TICKS  = 80
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ticker,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req0_c,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [31:0] req1_c,
    output logic [7:0]  bus_value,
    output logic        read_enable,
    output logic        busy,
    output logic        grant_id,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  o_state
);
    // Handshake: a frame transfers on the rising clock edge where reqN_valid and
    // reqN_ready are both 1; ready is raised only in IDLE, only for the winner.
    localparam int MAX_TICKS = (LOAD_TICKS > GAP_TICKS) ? LOAD_TICKS : GAP_TICKS;
    localparam int TW = $clog2(MAX_TICKS + 1);
    localparam logic [TW-1:0] LOAD_LAST = TW'(LOAD_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_ticker_d;
    logic          r_entry;
    logic          r_prio;
    logic          r_err;
    logic          r_grant;
    logic [TW-1:0] r_tick_cnt;
    logic [3:0]    r_byte_idx;
    logic [3:0]    r_len_m1;
    logic [111:0]  r_frame;

    logic          w_edge;
    logic          w_sel0;
    logic          w_sel1;
    logic          w_accept;
    logic          w_legal;
    logic          w_tick_done;
    logic [7:0]    w_op;
    logic [31:0]   w_a;
    logic [31:0]   w_b;
    logic [31:0]   w_c;
    logic [111:0]  w_frame;
    logic [3:0]    w_len_m1;

    assign w_edge = ticker & ~r_ticker_d;

    // r_prio = 1 means req1 holds priority (req0 was served last).
    assign w_sel1 = req1_valid & (~req0_valid | r_prio);
    assign w_sel0 = req0_valid & ~w_sel1;

    assign req0_ready = reset_n & (r_state == IDLE) & w_sel0;
    assign req1_ready = reset_n & (r_state == IDLE) & w_sel1;
    assign w_accept   = req0_ready | req1_ready;

    assign w_op = w_sel1 ? req1_op : req0_op;
    assign w_a  = w_sel1 ? req1_a  : req0_a;
    assign w_b  = w_sel1 ? req1_b  : req0_b;
    assign w_c  = w_sel1 ? req1_c  : req0_c;

    // Frames are left-aligned in 14 bytes; unused tail bytes stay zero.
    always_comb begin
        w_legal  = 1'b1;
        w_len_m1 = 4'd0;
        w_frame  = '0;
        case (w_op)
            8'd0: begin
                w_frame  = {w_op, w_a, w_b, 8'h00, 32'h0};
                w_len_m1 = 4'd9;
            end
            8'd2: begin
                w_frame  = {w_op, w_a, w_b, w_c, 8'h00};
                w_len_m1 = 4'd13;
            end
            8'd3: begin
                w_frame  = {w_op, w_a, 8'h00, 64'h0};
                w_len_m1 = 4'd5;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Edges seen on the first cycle of a phase are ignored via r_entry.
    assign w_tick_done = ~r_entry & w_edge &
                         (r_tick_cnt == ((r_state == LOAD) ? LOAD_LAST : GAP_LAST));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept && w_legal) w_next = LOAD;
            LOAD: if (w_tick_done) w_next = GAP;
            GAP: begin
                if (w_tick_done) begin
                    w_next = (r_byte_idx == r_len_m1) ? DONE : LOAD;
                end
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign read_enable = (r_state != LOAD);
    assign bus_value   = ((r_state == LOAD) || (r_state == GAP)) ? r_frame[111:104] : 8'h00;
    assign busy        = (r_state != IDLE);
    assign frame_done  = (r_state == DONE);
    assign frame_err   = r_err;
    assign grant_id    = r_grant;
    assign o_state     = r_state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_ticker_d <= 1'b0;
            r_entry    <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_ticker_d <= ticker;
            r_entry    <= (w_next != r_state) && ((w_next == LOAD) || (w_next == GAP));
            if (w_next != r_state) begin
                r_tick_cnt <= '0;
            end else if (((r_state == LOAD) || (r_state == GAP)) && !r_entry && w_edge) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    // The pointer moves away from whichever requester was just served,
    // including requesters whose frame is dropped as illegal.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_frame    <= '0;
            r_len_m1   <= 4'd0;
            r_byte_idx <= 4'd0;
            r_grant    <= 1'b0;
            r_prio     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_legal;
            if (w_accept) begin
                r_grant <= w_sel1;
                r_prio  <= ~w_sel1;
                if (w_legal) begin
                    r_frame    <= w_frame;
                    r_len_m1   <= w_len_m1;
                    r_byte_idx <= 4'd0;
                end
            end else if ((r_state == GAP) && (w_next == LOAD)) begin
                r_frame <= {r_frame[103:0], 8'h00};
                if (r_byte_idx != r_len_m1) begin
                    r_byte_idx <= r_byte_idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: frames are predicted from the opcode
// rules into a byte queue and checked by an independent output monitor.
module tb_cmd_sequencer;
    localparam int LT = 2;
    localparam int GT = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ticker = 1'b0;
    logic        req0_valid, req0_ready;
    logic [7:0]  req0_op;
    logic [31:0] req0_a, req0_b, req0_c;
    logic        req1_valid, req1_ready;
    logic [7:0]  req1_op;
    logic [31:0] req1_a, req1_b, req1_c;
    logic [7:0]  bus_value;
    logic        read_enable, busy, grant_id, frame_done, frame_err;
    logic [1:0]  st;

    cmd_sequencer #(.LOAD_TICKS(LT), .GAP_TICKS(GT)) dut (
        .clock(clock), .reset_n(reset_n), .ticker(ticker),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
        .bus_value(bus_value), .read_enable(read_enable), .busy(busy),
        .grant_id(grant_id), .frame_done(frame_done), .frame_err(frame_err),
        .o_state(st)
    );

    // Clock and ticker (ticker half-period 2..5 clocks, so phases vary).
    always #5 clock = ~clock;

    initial begin
        forever begin
            repeat ($urandom_range(2, 5)) @(posedge clock);
            #1 ticker = ~ticker;
        end
    end

    // Scoreboard state
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    int          exp_len_q[$];
    logic        exp_gid_q[$];
    int          err_pending = 0;
    logic        last_served = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred, expected none at %0t", name, $time);
    endtask

    function automatic logic is_legal(input logic [7:0] op);
        return (op == 8'd0) || (op == 8'd2) || (op == 8'd3);
    endfunction

    // Reference model: frame = op, fields MSB-first, trailing 0x00.
    task automatic push_frame(input logic id, input logic [7:0] op,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        int n;
        if (!is_legal(op)) begin
            err_pending++;
            return;
        end
        exp_q.push_back(op);
        n = 1;
        for (int i = 3; i >= 0; i--) begin exp_q.push_back(a[8*i +: 8]); n++; end
        if (op != 8'd3) for (int i = 3; i >= 0; i--) begin exp_q.push_back(b[8*i +: 8]); n++; end
        if (op == 8'd2) for (int i = 3; i >= 0; i--) begin exp_q.push_back(c[8*i +: 8]); n++; end
        exp_q.push_back(8'h00);
        n++;
        exp_len_q.push_back(n);
        exp_gid_q.push_back(id);
    endtask

    // Driver tasks
    task automatic drive(input logic id, input logic v, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_c = c;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_c = c;
        end
    endtask

    task automatic wait_ready(input logic id, output logic ok);
        int w = 0;
        ok = id ? req1_ready : req0_ready;
        while (!ok && w < 4000) begin
            @(negedge clock);
            #1;
            w++;
            ok = id ? req1_ready : req0_ready;
        end
        if (!ok) fail_evt("ready_timeout");
    endtask

    // Called just before the accepting edge; scrambles inputs afterwards.
    task automatic accept(input logic id, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        push_frame(id, op, a, b, c);
        last_served = id;
        @(posedge clock);
        #1;
        drive(id, 1'b0, 8'($urandom), $urandom, $urandom, $urandom);
        if (!is_legal(op)) begin
            @(negedge clock);
            check("err_pulse", frame_err, 1'b1);
            check("err_read_enable", read_enable, 1'b1);
            check("err_state_idle", st, 2'd0);
            @(negedge clock);
            check("err_pulse_end", frame_err, 1'b0);
        end
    endtask

    task automatic send(input logic id, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic ok;
        @(negedge clock);
        drive(id, 1'b1, op, a, b, c);
        #1;
        wait_ready(id, ok);
        if (ok) accept(id, op, a, b, c);
        else drive(id, 1'b0, op, a, b, c);
    endtask

    task automatic send_pair(input logic [7:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                             input logic [31:0] c0, input logic [7:0] op1, input logic [31:0] a1,
                             input logic [31:0] b1, input logic [31:0] c1);
        logic ok;
        logic w;
        int   cnt = 0;
        @(negedge clock);
        drive(1'b0, 1'b1, op0, a0, b0, c0);
        drive(1'b1, 1'b1, op1, a1, b1, c1);
        #1;
        while (!(req0_ready | req1_ready) && cnt < 4000) begin
            @(negedge clock);
            #1;
            cnt++;
        end
        if (!(req0_ready | req1_ready)) begin
            fail_evt("pair_ready_timeout");
            drive(1'b0, 1'b0, op0, a0, b0, c0);
            drive(1'b1, 1'b0, op1, a1, b1, c1);
            return;
        end
        w = ~last_served;
        check("rr_winner", req1_ready, w);
        check("rr_one_ready", req0_ready & req1_ready, 1'b0);
        if (w) accept(1'b1, op1, a1, b1, c1);
        else   accept(1'b0, op0, a0, b0, c0);
        wait_ready(~w, ok);
        if (ok) begin
            if (w) accept(1'b0, op0, a0, b0, c0);
            else   accept(1'b1, op1, a1, b1, c1);
        end else begin
            drive(~w, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0);
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_len_q.size() != 0 || busy) && w < 6000) begin
            @(negedge clock);
            w++;
        end
        if (w >= 6000) fail_evt("drain_timeout");
        check("bytes_left", exp_q.size(), 0);
    endtask

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 7))
            0, 1:    return 8'd0;
            2, 3:    return 8'd2;
            4, 5:    return 8'd3;
            6:       return 8'd1;
            default: return 8'($urandom_range(4, 255));
        endcase
    endfunction

    function automatic logic [7:0] rand_legal_op();
        case ($urandom_range(0, 2))
            0:       return 8'd0;
            1:       return 8'd2;
            default: return 8'd3;
        endcase
    endfunction

    // Monitor: tracks load/gap phases from read_enable/busy, pops expectations.
    int         ph = 0;
    int         edges = 0;
    logic       last_edge = 1'b0;
    logic [7:0] cur_b = 8'h00;
    int         fbytes = 0;
    logic       tk_prev = 1'b0;

    always @(negedge clock) begin : monitor
        logic ed;
        int   cph;
        ed = ticker & ~tk_prev;
        tk_prev = ticker;
        if (!reset_n) begin
            ph = 0;
            fbytes = 0;
            edges = 0;
            last_edge = 1'b0;
        end else begin
            if (busy && !read_enable) cph = 1;
            else if (busy && read_enable && !frame_done) cph = 2;
            else cph = 0;
            if (cph != ph) begin
                if (ph == 1) begin
                    check("load_edges", edges, LT);
                    check("load_exit_after_edge", last_edge, 1'b1);
                end
                if (ph == 2) begin
                    check("gap_edges", edges, GT);
                    check("gap_exit_after_edge", last_edge, 1'b1);
                end
                if (cph == 1) begin
                    if (exp_q.size() == 0) fail_evt("unexpected_byte");
                    else check("byte", bus_value, exp_q.pop_front());
                    cur_b = bus_value;
                    fbytes++;
                end else if (cph == 2) begin
                    check("byte_hold", bus_value, cur_b);
                end
                edges = 0;
                last_edge = 1'b0;
            end else if (cph != 0) begin
                if (ed) edges++;
                last_edge = ed;
                check("byte_hold", bus_value, cur_b);
            end
            ph = cph;
            if (frame_done) begin
                if (exp_len_q.size() == 0) begin
                    fail_evt("unexpected_frame_done");
                end else begin
                    check("frame_len", fbytes, exp_len_q.pop_front());
                    check("grant_id", grant_id, exp_gid_q.pop_front());
                end
                fbytes = 0;
            end
            if (frame_err) begin
                if (err_pending == 0) fail_evt("unexpected_frame_err");
                else err_pending--;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        int w;
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 8'd0, 32'h1, 32'h2, 32'h3);
        drive(1'b1, 1'b1, 8'd3, 32'h4, 32'h5, 32'h6);
        #12;
        check("rst_read_enable", read_enable, 1'b1);
        check("rst_bus_value", bus_value, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_ready1", req1_ready, 1'b0);
        check("rst_grant_id", grant_id, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_state", st, 2'd0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 32'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 8'd0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clock);

        // Directed frames
        send(1'b0, 8'd0, 32'h0000020C, 32'h00000064, $urandom);
        drain();
        send(1'b1, 8'd3, 32'h00000117, $urandom, $urandom);
        drain();
        send_pair(8'd0, 32'h11111111, 32'h22222222, 32'h0, 8'd3, 32'h33333333, 32'h0, 32'h0);
        drain();
        send_pair(8'd3, 32'hA5A5A5A5, 32'h0, 32'h0, 8'd2, 32'h01020304, 32'h05060708, 32'h090A0B0C);
        drain();
        send(1'b0, 8'd1, $urandom, $urandom, $urandom);
        drain();

        // Randomized traffic
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0)
                send_pair(rand_legal_op(), $urandom, $urandom, $urandom,
                          rand_legal_op(), $urandom, $urandom, $urandom);
            else
                send(1'($urandom_range(0, 1)), rand_op(), $urandom, $urandom, $urandom);
        end
        drain();

        // Reset during byte 7 of a transfer, then resubmit
        send(1'b0, 8'd2, 32'h00000117, 32'h00000013, 32'h00000064);
        w = 0;
        while (fbytes != 7 && w < 3000) begin
            @(negedge clock);
            w++;
        end
        if (fbytes != 7) fail_evt("byte7_timeout");
        #2;
        drive(1'b0, 1'b1, 8'd2, 32'h00000117, 32'h00000013, 32'h00000064);
        reset_n = 1'b0;
        #1;
        check("midrst_read_enable", read_enable, 1'b1);
        check("midrst_bus_value", bus_value, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready0", req0_ready, 1'b0);
        check("midrst_frame_done", frame_done, 1'b0);
        exp_q.delete();
        exp_len_q.delete();
        exp_gid_q.delete();
        err_pending = 0;
        last_served = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("midrst_no_done", frame_done, 1'b0);
        end
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 32'h0, 32'h0, 32'h0);
        send(1'b0, 8'd2, 32'h00000117, 32'h00000013, 32'h00000064);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
